// File: rtl/sub16_pkg.sv
// Shared definitions for the digit-serial 16-bit subtractor: operand width,
// controller state encoding and the pass-count helper.
package sub16_pkg;

    localparam int WIDTH_C = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_passes(input int digit);
        return WIDTH_C / digit;
    endfunction

endpackage

// File: rtl/sub_digit_bla.sv
// One DIGIT-wide borrow-lookahead subtract slice: d_s = a_s - b_s - bi.
// Works as an adder on a_s and ~b_s with carry-in ~bi; borrow-out is ~carry-out.
module sub_digit_bla #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_s,
    input  logic [DIGIT-1:0] b_s,
    input  logic             bi,
    output logic [DIGIT-1:0] d_s,
    output logic             bo
);

    logic [DIGIT-1:0] gen;
    logic [DIGIT-1:0] prop;
    logic [DIGIT:0]   carry;
    logic             term_or;
    logic             prop_prod;

    assign gen  = a_s & ~b_s;
    assign prop = a_s ^ ~b_s;

    // Each carry is the flattened OR of generate terms gated by the propagate chain.
    always_comb begin
        carry     = '0;
        term_or   = 1'b0;
        prop_prod = 1'b1;
        carry[0]  = ~bi;
        for (int i = 0; i < DIGIT; i++) begin
            term_or   = 1'b0;
            prop_prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                term_or   = term_or | (prop_prod & gen[j]);
                prop_prod = prop_prod & prop[j];
            end
            carry[i+1] = term_or | (prop_prod & carry[0]);
        end
    end

    assign d_s = prop ^ carry[DIGIT-1:0];
    assign bo  = ~carry[DIGIT];

endmodule

// File: rtl/serial_subtractor16.sv
// Digit-serial 16-bit subtractor D = A - B - Bin, DIGIT bits per clock, start/done handshake.
// Optional signed-overflow output v is built only when SUB16_OVERFLOW_EN is defined.
//   state | meaning
//   IDLE  | waiting for start; last result held
//   RUN   | one slice per clock, idx selects the digit
//   DONE  | one-cycle done pulse; start here begins the next op directly
module serial_subtractor16
    import sub16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB16_OVERFLOW_EN
    ,
    output logic             v
`endif
);

    if (WIDTH != WIDTH_C) begin : g_bad_width
        $fatal(1, "serial_subtractor16: WIDTH must be 16");
    end
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 || DIGIT == 16)) begin : g_bad_digit
        $fatal(1, "serial_subtractor16: DIGIT must be 1, 2, 4, 8 or 16");
    end

    localparam int N     = n_passes(DIGIT);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int OFS_W = $clog2(WIDTH_C);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [WIDTH_C-1:0] a_q, a_d;
    logic [WIDTH_C-1:0] b_q, b_d;
    logic [WIDTH_C-1:0] diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               v_q, v_d;

    logic [OFS_W-1:0]   ofs;
    logic [DIGIT-1:0]   slice_a;
    logic [DIGIT-1:0]   slice_b;
    logic [DIGIT-1:0]   slice_d;
    logic               slice_bo;
    logic               accept;

    assign ofs     = OFS_W'(int'(idx_q) * DIGIT);
    assign slice_a = a_q[ofs +: DIGIT];
    assign slice_b = b_q[ofs +: DIGIT];

    sub_digit_bla #(.DIGIT(DIGIT)) u_slice (
        .a_s (slice_a),
        .b_s (slice_b),
        .bi  (borrow_q),
        .d_s (slice_d),
        .bo  (slice_bo)
    );

    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        idx_d    = idx_q;
        v_d      = v_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                diff_d[ofs +: DIGIT] = slice_d;
                borrow_d = slice_bo;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    bout_d  = slice_bo;
                    idx_d   = '0;
                    // Overflow judged on the finished difference, including this last slice.
                    v_d = (a_q[WIDTH_C-1] != b_q[WIDTH_C-1]) && (diff_d[WIDTH_C-1] != a_q[WIDTH_C-1]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = RUN;
            a_d      = a;
            b_d      = b;
            borrow_d = bin;
            diff_d   = '0;
            bout_d   = 1'b0;
            idx_d    = '0;
            v_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            idx_q    <= '0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            idx_q    <= idx_d;
            v_q      <= v_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = diff_q;
    assign bout = bout_q;

`ifdef SUB16_OVERFLOW_EN
    assign v = v_q;
`else
    logic unused_v;
    assign unused_v = v_q ^ v_d;
`endif

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed and random checks of serial_subtractor16 for DIGIT = 1, 4 and 16.
module tb_serial_subtractor16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];
    logic        bin_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [15:0] d_v     [3];
    logic        bout_v  [3];
`ifdef SUB16_OVERFLOW_EN
    logic        v_v     [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int nk      [3] = '{16, 4, 1};
    int digit_k [3] = '{1, 4, 16};

    always #5 clk = ~clk;

    serial_subtractor16 #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .bin(bin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .d(d_v[0]), .bout(bout_v[0])
`ifdef SUB16_OVERFLOW_EN
        , .v(v_v[0])
`endif
    );

    serial_subtractor16 #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .bin(bin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .d(d_v[1]), .bout(bout_v[1])
`ifdef SUB16_OVERFLOW_EN
        , .v(v_v[1])
`endif
    );

    serial_subtractor16 #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .bin(bin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .d(d_v[2]), .bout(bout_v[2])
`ifdef SUB16_OVERFLOW_EN
        , .v(v_v[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int k, input string name);
        return $sformatf("D%0d/%s", digit_k[k], name);
    endfunction

    function automatic logic get_v(input int k);
`ifdef SUB16_OVERFLOW_EN
        return v_v[k];
`else
        return 1'b0;
`endif
    endfunction

    // Start one op, scramble the inputs after acceptance, wait (bounded) for done.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic bi,
                          output logic [15:0] dq, output logic bq, output logic vq, output int cyc);
        @(posedge clk); #1;
        start_v[k] = 1'b1; a_v[k] = a; b_v[k] = b; bin_v[k] = bi;
        cyc = 0;
        while (cyc < 64) begin
            @(posedge clk); #1;
            start_v[k] = 1'b0;
            a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); bin_v[k] = 1'($urandom);
            cyc++;
            if (done_v[k]) break;
        end
        if (!done_v[k]) chk(tg(k, "done_timeout"), 32'(done_v[k]), 1);
        dq = d_v[k]; bq = bout_v[k]; vq = get_v(k);
    endtask

    task automatic op_check(input int k, input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic bi, input logic [15:0] exp_d, input logic exp_b);
        logic [15:0] dq;
        logic        bq, vq;
        int          cyc;
        run_op(k, a, b, bi, dq, bq, vq, cyc);
        chk(tg(k, {name, "_d"}), 32'(dq), 32'(exp_d));
        chk(tg(k, {name, "_bout"}), 32'(bq), 32'(exp_b));
        chk(tg(k, {name, "_lat"}), 32'(cyc), 32'(nk[k] + 1));
        @(posedge clk); #1;
        chk(tg(k, {name, "_pulse"}), 32'(done_v[k]), 0);
        chk(tg(k, {name, "_hold"}), 32'(d_v[k]), 32'(exp_d));
    endtask

    initial begin
        logic [15:0] dq, ra, rb;
        logic        bq, vq, rbi;
        logic [16:0] exp17;
        int          cyc, cnt, pre;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; bin_v[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(tg(k, "rst_busy"), 32'(busy_v[k]), 0);
            chk(tg(k, "rst_done"), 32'(done_v[k]), 0);
            chk(tg(k, "rst_d"), 32'(d_v[k]), 0);
            chk(tg(k, "rst_bout"), 32'(bout_v[k]), 0);
            chk(tg(k, "rst_v"), 32'(get_v(k)), 0);
        end
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            op_check(k, "t1", 16'd9431, 16'd1032, 1'b0, 16'd8399, 1'b0);
            op_check(k, "t2", 16'd1032, 16'd9431, 1'b0, 16'd57137, 1'b1);
            op_check(k, "t3wrap", 16'd0, 16'd0, 1'b1, 16'hFFFF, 1'b1);
            op_check(k, "t3eq", 16'd65000, 16'd65000, 1'b0, 16'd0, 1'b0);

            // start held through RUN with new operands, then accepted in DONE
            @(posedge clk); #1;
            start_v[k] = 1'b1; a_v[k] = 16'd9431; b_v[k] = 16'd1032; bin_v[k] = 1'b0;
            cyc = 0;
            while (cyc < 64) begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 1) begin a_v[k] = 16'd100; b_v[k] = 16'd50; end
                if (done_v[k]) break;
            end
            chk(tg(k, "t4_first_d"), 32'(d_v[k]), 8399);
            chk(tg(k, "t4_first_lat"), 32'(cyc), 32'(nk[k] + 1));
            @(posedge clk); #1;
            start_v[k] = 1'b0;
            chk(tg(k, "t4_b2b_busy"), 32'(busy_v[k]), 1);
            chk(tg(k, "t4_b2b_done"), 32'(done_v[k]), 0);
            cyc = 0;
            while (cyc < 64) begin
                @(posedge clk); #1;
                cyc++;
                if (done_v[k]) break;
            end
            chk(tg(k, "t4_second_d"), 32'(d_v[k]), 50);
            chk(tg(k, "t4_second_bout"), 32'(bout_v[k]), 0);
            chk(tg(k, "t4_second_lat"), 32'(cyc), 32'(nk[k]));
            @(posedge clk); #1;

            // reset in the middle of RUN
            @(posedge clk); #1;
            start_v[k] = 1'b1; a_v[k] = 16'd9431; b_v[k] = 16'd1032; bin_v[k] = 1'b0;
            pre = (nk[k] >= 4) ? 3 : 1;
            repeat (pre) @(posedge clk);
            #1;
            start_v[k] = 1'b0;
            chk(tg(k, "t5_pre_busy"), 32'(busy_v[k]), 1);
            #2 rst = 1'b1;
            #1;
            chk(tg(k, "t5_busy"), 32'(busy_v[k]), 0);
            chk(tg(k, "t5_d"), 32'(d_v[k]), 0);
            chk(tg(k, "t5_done"), 32'(done_v[k]), 0);
            #2 rst = 1'b0;
            cnt = 0;
            for (int i = 0; i < nk[k] + 3; i++) begin
                @(posedge clk); #1;
                if (done_v[k]) cnt++;
            end
            chk(tg(k, "t5_no_done"), 32'(cnt), 0);
            op_check(k, "t5_after", 16'd9431, 16'd1032, 1'b0, 16'd8399, 1'b0);

`ifdef SUB16_OVERFLOW_EN
            run_op(k, 16'h8000, 16'h0001, 1'b0, dq, bq, vq, cyc);
            chk(tg(k, "t6a_d"), 32'(dq), 32'h7FFF);
            chk(tg(k, "t6a_v"), 32'(vq), 1);
            run_op(k, 16'h7FFF, 16'hFFFF, 1'b0, dq, bq, vq, cyc);
            chk(tg(k, "t6b_d"), 32'(dq), 32'h8000);
            chk(tg(k, "t6b_v"), 32'(vq), 1);
            run_op(k, 16'd5, 16'd3, 1'b0, dq, bq, vq, cyc);
            chk(tg(k, "t6c_d"), 32'(dq), 2);
            chk(tg(k, "t6c_v"), 32'(vq), 0);
`endif

            for (int r = 0; r < 8; r++) begin
                ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
                exp17 = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
                run_op(k, ra, rb, rbi, dq, bq, vq, cyc);
                chk(tg(k, "rand_d"), 32'(dq), 32'(exp17[15:0]));
                chk(tg(k, "rand_bout"), 32'(bq), 32'(exp17[16]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
